half_adder: RTL and testbench

- Single-bit half adder; core outputs are pure gate-level combinational: sum = a XOR b, carry = a AND b.
- Adds a registered copy of the result with a valid strobe, plus a saturating carry-event counter, so the block can sit in a clocked datapath and be observed.
- Leaf cell, used standalone or as a building block for wider adders.

---
 rtl/half_adder.sv | 76 +++++++
 tb/tb_half_adder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// ============================================================================
//  Module   : half_adder
//  Purpose  : Single-bit half adder, with registered result, valid strobe and
//             a saturating carry-event counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
   input  logic             cnt_clr,
   output logic             s,
   output logic             c,
   output logic             s_q,
   output logic             c_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic             s_d;
   logic             c_d;
   logic             out_valid_d;
   logic [CNT_W-1:0] carry_cnt_d;
   logic [CNT_W-1:0] carry_cnt_q;

   // Core gates stay outside the clocked domain so they keep working in reset.
   assign s = a ^ b;
   assign c = a & b;

   always_comb begin
      s_d         = s_q;
      c_d         = c_q;
      out_valid_d = in_valid;
      carry_cnt_d = carry_cnt_q;

      if (in_valid) begin
         s_d = s;
         c_d = c;
      end

      if (cnt_clr) begin
         carry_cnt_d = CNT_ZERO;
      end else if (in_valid && c && (carry_cnt_q != CNT_MAX)) begin
         carry_cnt_d = carry_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q         <= 1'b0;
         c_q         <= 1'b0;
         out_valid   <= 1'b0;
         carry_cnt_q <= CNT_ZERO;
      end else begin
         s_q         <= s_d;
         c_q         <= c_d;
         out_valid   <= out_valid_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign carry_cnt = carry_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_half_adder.sv
// ============================================================================
//  Module   : tb_half_adder
//  Purpose  : Self-checking bench for half_adder (CNT_W=8 and CNT_W=2 copies).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a, b, in_valid, cnt_clr;
   logic       s8, c8, s_q8, c_q8, ov8;
   logic [7:0] cnt8;
   logic       s2, c2, s_q2, c_q2, ov2;
   logic [1:0] cnt2;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: the outcome of the last accepted operation and counts.
   int exp_s, exp_c, exp_ov, exp_cnt8, exp_cnt2;

   always #5 clk = ~clk;

   half_adder #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .s(s8), .c(c8), .s_q(s_q8), .c_q(c_q8),
      .out_valid(ov8), .carry_cnt(cnt8)
   );

   half_adder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .s(s2), .c(c2), .s_q(s_q2), .c_q(c_q2),
      .out_valid(ov2), .carry_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_comb(input string tag);
      check({tag, "_s8"}, 32'(s8), 32'((a + b) % 2));
      check({tag, "_c8"}, 32'(c8), 32'((a + b) / 2));
      check({tag, "_s2"}, 32'(s2), 32'((a + b) % 2));
      check({tag, "_c2"}, 32'(c2), 32'((a + b) / 2));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_sq"},   32'(s_q8), 32'(exp_s));
      check({tag, "_cq"},   32'(c_q8), 32'(exp_c));
      check({tag, "_ov"},   32'(ov8),  32'(exp_ov));
      check({tag, "_cnt8"}, 32'(cnt8), 32'(exp_cnt8));
      check({tag, "_sq2"},  32'(s_q2), 32'(exp_s));
      check({tag, "_cq2"},  32'(c_q2), 32'(exp_c));
      check({tag, "_ov2"},  32'(ov2),  32'(exp_ov));
      check({tag, "_cnt2"}, 32'(cnt2), 32'(exp_cnt2));
   endtask

   // Drive one operation mid-cycle, let it be captured, then compare.
   task automatic step(input logic ia, input logic ib, input logic iv,
                       input logic iclr, input string tag);
      @(negedge clk);
      a = ia; b = ib; in_valid = iv; cnt_clr = iclr;
      #1 check_comb(tag);
      @(posedge clk);
      exp_ov = int'(iv);
      if (iv) begin
         exp_s = (int'(ia) + int'(ib)) % 2;
         exp_c = (int'(ia) + int'(ib)) / 2;
      end
      if (iclr) begin
         exp_cnt8 = 0;
         exp_cnt2 = 0;
      end else if (iv && ia && ib) begin
         exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : exp_cnt8;
         exp_cnt2 = (exp_cnt2 < 3)   ? exp_cnt2 + 1 : exp_cnt2;
      end
      #1 check_regs(tag);
   endtask

   initial begin
      logic ra, rb;
      rst_n = 1'b0; a = 1'b0; b = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
      exp_s = 0; exp_c = 0; exp_ov = 0; exp_cnt8 = 0; exp_cnt2 = 0;

      // Truth table during reset, 1 ns apart, no clock dependence.
      for (int i = 0; i < 4; i++) begin
         a = i[1]; b = i[0];
         #1 check_comb("tt");
      end
      check_regs("reset");

      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 1'b1, 1'b1, 1'b0, "first");
      step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

      for (int i = 0; i < 10; i++) begin
         ra = 1'($urandom);
         rb = 1'($urandom);
         step(ra, rb, 1'b1, 1'b0, "rand");
      end
      for (int i = 0; i < 6; i++) begin
         ra = 1'($urandom);
         rb = 1'($urandom);
         step(ra, rb, 1'($urandom), 1'b0, "randv");
      end

      step(1'b0, 1'b0, 1'b0, 1'b1, "clr");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "sat");
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr_prio");
      step(1'b1, 1'b1, 1'b1, 1'b0, "after_clr");
      step(1'b0, 1'b1, 1'b1, 1'b0, "pre_rst");

      // Asynchronous reset between edges.
      @(negedge clk);
      #2 rst_n = 1'b0;
      exp_s = 0; exp_c = 0; exp_ov = 0; exp_cnt8 = 0; exp_cnt2 = 0;
      #1 check_regs("async_rst");
      a = 1'b1; b = 1'b0;
      #1 check_comb("rst_comb10");
      a = 1'b1; b = 1'b1;
      #1 check_comb("rst_comb11");
      @(posedge clk);
      #1 check_regs("rst_hold");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
